// File: rtl/addr_gen_ctrl.sv
// Tile sequencer for the even/odd address generator: CLEAR, then L even and L odd beats per row pair, R pairs per tile, T tiles.
// Strobes decode combinationally from state, counters and hold; start to first sync_clr takes 1 cycle; done fires T*(2+2*R*L)+1 cycles after start.
// hold freezes CLEAR/EVEN/ODD and masks their strobes; TILE_END and DONE ignore it; abort returns to IDLE next cycle with no done.
module addr_gen_ctrl #(
    parameter int CNT_W  = 6,
    parameter int TILE_W = 8
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              hold,
    input  logic [CNT_W-1:0]  cfg_row_len,
    input  logic [CNT_W-1:0]  cfg_rows,
    input  logic [TILE_W-1:0] cfg_tiles,
    output logic              en,
    output logic              sync_clr,
    output logic              inc_even,
    output logic              inc_odd,
    output logic [1:0]        arv_tilev,
    output logic              busy,
    output logic              done,
    output logic [TILE_W-1:0] tile_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_EVEN,
        S_ODD,
        S_TILE_END,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   row_cnt;
    logic [TILE_W-1:0]  tile_cnt;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   rows_q;
    logic [TILE_W-1:0]  tiles_q;

    logic cfg_ok;
    logic last_beat;
    logic last_row;
    logic last_tile;

    // A zero in any field means there is nothing to walk; such a start goes straight to DONE.
    assign cfg_ok    = (cfg_row_len != '0) && (cfg_rows != '0) && (cfg_tiles != '0);

    // Compares run at full width against cfg-1, so the all-ones config is a legal maximum.
    assign last_beat = (beat_cnt == len_q - CNT_W'(1));
    assign last_row  = (row_cnt  == rows_q - CNT_W'(1));
    assign last_tile = (tile_cnt == tiles_q - TILE_W'(1));

    assign tile_idx  = tile_cnt;

    // Output decode: strobes come only from state, counters and hold.
    always_comb begin
        en       = 1'b0;
        sync_clr = 1'b0;
        inc_even = 1'b0;
        inc_odd  = 1'b0;
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        case (state)
            S_CLEAR: begin
                en       = !hold;
                sync_clr = !hold;
            end
            S_EVEN: begin
                en       = !hold;
                inc_even = !hold && last_beat;
            end
            S_ODD: begin
                en      = !hold;
                inc_odd = !hold && last_beat;
            end
            default: ;
        endcase
    end

    // Sequencer: state, beat/row/tile counters, latched config and per-tile row-type flags.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            row_cnt   <= '0;
            tile_cnt  <= '0;
            len_q     <= '0;
            rows_q    <= '0;
            tiles_q   <= '0;
            arv_tilev <= 2'b00;
        end else if (abort) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            row_cnt   <= '0;
            tile_cnt  <= '0;
            arv_tilev <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            len_q    <= cfg_row_len;
                            rows_q   <= cfg_rows;
                            tiles_q  <= cfg_tiles;
                            tile_cnt <= '0;
                            state    <= S_CLEAR;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_CLEAR: begin
                    if (!hold) begin
                        beat_cnt  <= '0;
                        row_cnt   <= '0;
                        arv_tilev <= 2'b00;
                        state     <= S_EVEN;
                    end
                end
                S_EVEN: begin
                    if (!hold) begin
                        if (last_beat) begin
                            beat_cnt     <= '0;
                            arv_tilev[0] <= 1'b1;
                            state        <= S_ODD;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                S_ODD: begin
                    if (!hold) begin
                        if (last_beat) begin
                            beat_cnt     <= '0;
                            arv_tilev[1] <= 1'b1;
                            if (last_row) begin
                                state <= S_TILE_END;
                            end else begin
                                row_cnt <= row_cnt + CNT_W'(1);
                                state   <= S_EVEN;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                S_TILE_END: begin
                    if (last_tile) begin
                        state <= S_DONE;
                    end else begin
                        tile_cnt <= tile_cnt + TILE_W'(1);
                        state    <= S_CLEAR;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/addr_gen_ctrl.md
Name: addr_gen_ctrl

Overview:
Tile sequencer that drives the even/odd data address generator. It emits the `en`, `sync_clr`, `inc_even`, `inc_odd` and `arv_tilev` controls.
- A run walks `cfg_tiles` tiles.
- Each tile is `cfg_rows` even/odd row pairs.
- Each row is `cfg_row_len` beats.
- It sits between the NPU top-level control FSM (start/done handshake) and the address generator. It honours a memory-side `hold` stall and a synchronous `abort`.

Parameters:
- `CNT_W`, 6, width of the row-length and row-count config and their internal counters.
- `TILE_W`, 8, width of the tile-count config and tile counter.

Ports:
- `ck` input 1: clock, rising edge.
- `rst` input 1: asynchronous reset, active-low.
- `start` input 1: run request pulse; sampled only in IDLE.
- `abort` input 1: synchronous cancel; wins over every other input.
- `hold` input 1: stall; freezes sequencing while high.
- `cfg_row_len` input CNT_W: beats per row; latched on accepted start.
- `cfg_rows` input CNT_W: even/odd row pairs per tile; latched on accepted start.
- `cfg_tiles` input TILE_W: tiles per run; latched on accepted start.
- `en` output 1: address generator enable.
- `sync_clr` output 1: address generator synchronous clear.
- `inc_even` output 1: end-of-even-row strobe.
- `inc_odd` output 1: end-of-odd-row strobe.
- `arv_tilev` output 2: per-tile row-type valid flags, {odd_seen, even_seen}.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle completion pulse.
- `tile_idx` output TILE_W: index of the current tile, 0-based.

Behaviour:
- Reset (`rst` low, async): state IDLE; all counters 0; cfg registers 0; `arv_tilev`=0. All outputs 0.
- State register, counters (beat, row, tile), cfg registers and `arv_tilev` are flops.
- `en`, `sync_clr`, `inc_even`, `inc_odd`, `busy`, `done` are combinational decodes of state, counters and `hold`. There is no combinational path from `start`, `abort` or `cfg_*` to any output.
- States: IDLE, CLEAR, EVEN, ODD, TILE_END, DONE.
- IDLE: all strobes 0.
  - `start`=1 with all cfg fields nonzero: latch cfg, tile=0, next state CLEAR.
  - `start`=1 with any cfg field zero: next state DONE; no `en`/`sync_clr` is ever issued.
- CLEAR: `sync_clr`=1 and `en`=1 when `hold`=0.
  - On a non-held cycle: beat=0, row=0, `arv_tilev`<=00, next state EVEN.
  - With `hold`=1: outputs 0, stay in CLEAR.
- EVEN: `en`=!`hold`. Each non-held cycle beat++.
  - On the beat==`cfg_row_len`-1 non-held cycle: `inc_even`=1 in the same cycle, beat<=0, `arv_tilev`[0]<=1, next state ODD.
- ODD: same as EVEN, but with `inc_odd` and `arv_tilev`[1]. On its last beat:
  - If row==`cfg_rows`-1: next state TILE_END.
  - Otherwise: row++, next state EVEN.
- TILE_END: one cycle, `en`=0, `hold` ignored.
  - If tile==`cfg_tiles`-1: next state DONE.
  - Otherwise: tile++, next state CLEAR.
- DONE: `done`=1 for exactly one cycle, `busy`=1, next state IDLE. `tile_idx` and `arv_tilev` keep their values until the next CLEAR.
- `hold` in CLEAR/EVEN/ODD: `en`, `sync_clr`, `inc_*` forced 0; state and counters frozen.
- `abort`=1 in any state: next state IDLE; counters 0; `arv_tilev`<=00; no `done` pulse. Strobes in the abort cycle follow the current state as normal.
- `start` while busy is ignored. `cfg_*` changes while busy have no effect.
- Counter widths: the compare is against cfg-1 at full width, so the max config value 2^W-1 is legal. No wrap-around is possible because the counters reset on each compare.
- Timing without hold: start accepted at cycle 0, CLEAR at cycle 1, each tile lasts 2+2·R·L cycles, and `done` is high at cycle T·(2+2·R·L)+1.
- Reset asserted mid-run: immediate return to the reset values listed above; no `done`.

Test Plan:
- Basic run, L=4, R=2, T=1, start at cycle 0:
  - `sync_clr` at cycle 1.
  - `en` high cycles 1–17, low at 18.
  - `inc_even` at cycles 5 and 13; `inc_odd` at cycles 9 and 17.
  - `arv_tilev`=01 from cycle 6 and 11 from cycle 10.
  - `done` at cycle 19, `busy` low at cycle 20.
- Multi-tile, L=1, R=1, T=3:
  - `sync_clr` at cycles 1, 5, 9.
  - `tile_idx` 0→1→2 at cycles 5 and 9.
  - `arv_tilev` returns to 00 at cycles 2 and 6.
  - `done` at cycle 13.
- Hold, L=4, R=1, T=1, `hold`=1 for cycles 3–5:
  - `en` low during cycles 3–5.
  - `inc_even` moves from cycle 5 to cycle 8.
  - `done` moves from cycle 11 to cycle 14.
- Abort at cycle 7 of the basic run:
  - IDLE at cycle 8 with all outputs 0 and `arv_tilev`=00.
  - No `done`.
  - A fresh `start` at cycle 10 gives `sync_clr` at cycle 11.
- Zero config (`cfg_rows`=0) with start at cycle 0:
  - `done` at cycle 1.
  - `en` and `sync_clr` never asserted.
  - `start` pulses at cycles 3–6 of a busy run have no effect.
- Async `rst` low mid-EVEN, between clock edges: all outputs drop to 0 immediately, before the next edge.
